ball_motion: RTL
================

# ball_motion

Per-frame ball trajectory engine producing the `ball_x`/`ball_y` coordinates consumed by the pixel generator, the writer side of the ball-position interface. Sits between the user-input logic (shoot button, launch velocity) and the VGA drawing path. Integrates a simple gravity model once per video frame, detects a made basket, and holds the final position before re-arming.

## Interface
- `START_X`, 40: ball x at rest (pixels, top-left of ball sprite)
- `START_Y`, 400: ball y at rest
- `FLOOR_Y`, 460: y at which flight ends
- `X_MAX`, 624: rightmost legal x (640 − 16-px ball)
- `GRAVITY`, 1: vy increment per frame (px/frame²)
- `VY_MAX`, 31: vy saturation (positive, downward)
- `HOOP_X_L`, 520 / `HOOP_X_R`, 560: inclusive x window of hoop opening
- `HOOP_Y`, 200: y of hoop rim plane
- `HOLD_FRAMES`, 60: frames the landed ball stays displayed
- `clk` in 1: system/pixel clock
- `reset` in 1: synchronous, active-high
- `frame_tick` in 1: one-cycle pulse per frame, asserted at vertical-blank start
- `shoot` in 1: one-cycle launch request
- `launch_vx` in 8: signed launch x velocity, px/frame
- `launch_vy` in 8: signed launch y velocity, px/frame (negative = upward)
- `ball_x` out 10: current ball x
- `ball_y` out 10: current ball y
- `in_flight` out 1: high in FLIGHT
- `shot_done` out 1: one-cycle pulse on FLIGHT→HOLD
- `made` out 1: sticky basket flag, cleared on return to IDLE

## Operation
- States: IDLE, ARMED, FLIGHT, HOLD.
- IDLE: ball at (`START_X`,`START_Y`). `shoot`=1 → ARMED; `launch_vx`/`launch_vy` captured into vx/vy the same cycle.
- ARMED: next `frame_tick` → FLIGHT; position unchanged on that tick.
- FLIGHT, each `frame_tick`, computed with 11-bit signed arithmetic (position zero-extended, velocity sign-extended):
  - nx = x + vx, ny = y + vy; then vy ← min(vy + `GRAVITY`, `VY_MAX`).
  - nx < 0 → x=0, vx=0; nx > `X_MAX` → x=`X_MAX`, vx=0.
  - ny < 0 → y=0 (no bounce, vy continues integrating).
  - Made: vy > 0 (pre-update) and y < `HOOP_Y` ≤ ny and `HOOP_X_L` ≤ x ≤ `HOOP_X_R` → `made` ← 1.
  - ny ≥ `FLOOR_Y` → y=`FLOOR_Y`, `shot_done` pulse, → HOLD, hold counter cleared. Made check still evaluated on this tick.
- HOLD: position frozen; counter increments per `frame_tick`; on tick where counter reaches `HOLD_FRAMES`−1 → IDLE, position ← start, `made` ← 0.
- `shoot` ignored outside IDLE.
- `shoot` and `frame_tick` same cycle in IDLE: goes to ARMED only; launch on the next tick.

## Timing
- Reset values: `ball_x`=`START_X`, `ball_y`=`START_Y`, `in_flight`=0, `shot_done`=0, `made`=0, state IDLE, vx=vy=0, counter 0.
- Reset mid-flight or mid-hold: immediate return to the reset values above on the next edge.
- All outputs registered; state/position updated by a `frame_tick` are visible the cycle after the tick.
- Outputs change only on `frame_tick` cycles, or on a `shoot` cycle (state only), so the pixel generator sees stable coordinates for the whole active frame.
- Launch latency: `shoot` → first position change = 2 `frame_tick`s.

## Structure
- Shared package `ball_pkg`: state enum (IDLE/ARMED/FLIGHT/HOLD), screen constants (640×480, ball size 16), default hoop/floor constants reused by `basketballHoop` and `basketball`.
- No sub-module; integration, clamping, made detection and the hold counter are inline.

## Test plan
- Reset → `ball_x`=40, `ball_y`=400, `in_flight`=0, `made`=0; ticks without `shoot` leave values unchanged.
- `shoot` vx=10, vy=−20; tick1 → FLIGHT, (40,400); tick2 → (50,380); tick3 → (60,361).
- Bench override `HOOP_X_L`=30, `HOOP_X_R`=60, `HOOP_Y`=380; vx=0, vy=−8: y sequence 392,385,379,374,370,367,365,364,364,365,367,370,374,379,385; `made` set only on the 379→385 tick, not on ascent 385→379.
- vx=100, vy=−2 → x clamps to 624 on the 7th flight tick, vx=0; ball falls to y=460, `shot_done` pulses exactly once, `in_flight` drops.
- After landing, `shoot` during HOLD ignored; after 60 ticks → (40,400), `made`=0, IDLE.
- `reset` asserted at tick 5 of a flight → next cycle (40,400), IDLE; `shoot`+`frame_tick` same cycle → ARMED, no movement until the following tick.

Source files
------------

// File: rtl/ball_pkg.sv
// Shared constants and state type for the ball trajectory engine and its neighbours
// (hoop sprite, ball sprite).
package ball_pkg;

  localparam int unsigned ScreenW  = 640;
  localparam int unsigned ScreenH  = 480;
  localparam int unsigned BallSize = 16;

  // Coordinate register width and the signed width used for per-frame integration.
  localparam int unsigned CoordW = 10;
  localparam int unsigned VelW   = 8;
  localparam int unsigned MathW  = 11;

  localparam int unsigned DefStartX     = 40;
  localparam int unsigned DefStartY     = 400;
  localparam int unsigned DefFloorY     = 460;
  localparam int unsigned DefXMax       = ScreenW - BallSize;
  localparam int unsigned DefGravity    = 1;
  localparam int unsigned DefVyMax      = 31;
  localparam int unsigned DefHoopXL     = 520;
  localparam int unsigned DefHoopXR     = 560;
  localparam int unsigned DefHoopY      = 200;
  localparam int unsigned DefHoldFrames = 60;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StFlight,
    StHold
  } ball_state_e;

endpackage

// File: rtl/ball_motion.sv
// Per-frame ball trajectory engine: launches on shoot, integrates gravity once per
// frame_tick, detects a basket, and holds the landed ball before re-arming.
module ball_motion
  import ball_pkg::*;
#(
  parameter int unsigned START_X     = DefStartX,
  parameter int unsigned START_Y     = DefStartY,
  parameter int unsigned FLOOR_Y     = DefFloorY,
  parameter int unsigned X_MAX       = DefXMax,
  parameter int unsigned GRAVITY     = DefGravity,
  parameter int unsigned VY_MAX      = DefVyMax,
  parameter int unsigned HOOP_X_L    = DefHoopXL,
  parameter int unsigned HOOP_X_R    = DefHoopXR,
  parameter int unsigned HOOP_Y      = DefHoopY,
  parameter int unsigned HOLD_FRAMES = DefHoldFrames
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              shoot,
  input  logic [VelW-1:0]   launch_vx,
  input  logic [VelW-1:0]   launch_vy,
  output logic [CoordW-1:0] ball_x,
  output logic [CoordW-1:0] ball_y,
  output logic              in_flight,
  output logic              shot_done,
  output logic              made
);

  localparam int unsigned CntW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic signed [MathW-1:0] XMaxS   = MathW'(X_MAX);
  localparam logic signed [MathW-1:0] FloorS  = MathW'(FLOOR_Y);
  localparam logic signed [MathW-1:0] HoopYS  = MathW'(HOOP_Y);
  localparam logic signed [MathW-1:0] HoopXLS = MathW'(HOOP_X_L);
  localparam logic signed [MathW-1:0] HoopXRS = MathW'(HOOP_X_R);
  localparam logic signed [VelW:0]    VyMaxS  = (VelW + 1)'(VY_MAX);
  localparam logic [CntW-1:0]         HoldLast = CntW'(HOLD_FRAMES - 1);

  ball_state_e state_q, state_d;

  logic [CoordW-1:0]      x_q, x_d;
  logic [CoordW-1:0]      y_q, y_d;
  logic signed [VelW-1:0] vx_q, vx_d;
  logic signed [VelW-1:0] vy_q, vy_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   made_q, made_d;
  logic                   shot_done_q, shot_done_d;

  logic signed [MathW-1:0] pos_x, pos_y, vel_x, vel_y, nx, ny;
  logic signed [VelW:0]    vy_inc;
  logic [VelW-1:0]         vy_sat;
  logic                    tick_flight, tick_hold, landing, hold_done, hoop_hit, launch;

  // Shared datapath terms; positions are zero-extended, velocities sign-extended.
  always_comb begin
    pos_x  = {1'b0, x_q};
    pos_y  = {1'b0, y_q};
    vel_x  = {{(MathW - VelW){vx_q[VelW-1]}}, vx_q};
    vel_y  = {{(MathW - VelW){vy_q[VelW-1]}}, vy_q};
    nx     = pos_x + vel_x;
    ny     = pos_y + vel_y;
    vy_inc = {vy_q[VelW-1], vy_q} + (VelW + 1)'(GRAVITY);
    vy_sat = (vy_inc > VyMaxS) ? VelW'(VY_MAX) : vy_inc[VelW-1:0];

    launch      = (state_q == StIdle) && shoot;
    tick_flight = (state_q == StFlight) && frame_tick;
    tick_hold   = (state_q == StHold) && frame_tick;
    landing     = tick_flight && (ny >= FloorS);
    hold_done   = tick_hold && (cnt_q == HoldLast);

    // Rim crossed downward while the ball's left edge is inside the opening.
    hoop_hit = !vy_q[VelW-1] && (vy_q != '0) && (pos_y < HoopYS) && (ny >= HoopYS) &&
               (pos_x >= HoopXLS) && (pos_x <= HoopXRS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (launch) state_d = StArmed;
      StArmed:  if (frame_tick) state_d = StFlight;
      StFlight: if (landing) state_d = StHold;
      StHold:   if (hold_done) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    cnt_d       = cnt_q;
    made_d      = made_q;
    shot_done_d = 1'b0;

    if (launch) begin
      vx_d = launch_vx;
      vy_d = launch_vy;
    end

    if (tick_flight) begin
      vy_d = vy_sat;
      if (hoop_hit) made_d = 1'b1;

      if (nx[MathW-1]) begin
        x_d  = '0;
        vx_d = '0;
      end else if (nx > XMaxS) begin
        x_d  = CoordW'(X_MAX);
        vx_d = '0;
      end else begin
        x_d = nx[CoordW-1:0];
      end

      if (landing) begin
        y_d         = CoordW'(FLOOR_Y);
        shot_done_d = 1'b1;
        cnt_d       = '0;
      end else if (ny[MathW-1]) begin
        y_d = '0;
      end else begin
        y_d = ny[CoordW-1:0];
      end
    end

    if (tick_hold) begin
      if (hold_done) begin
        x_d    = CoordW'(START_X);
        y_d    = CoordW'(START_Y);
        made_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q         <= CoordW'(START_X);
      y_q         <= CoordW'(START_Y);
      vx_q        <= '0;
      vy_q        <= '0;
      cnt_q       <= '0;
      made_q      <= 1'b0;
      shot_done_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      cnt_q       <= cnt_d;
      made_q      <= made_d;
      shot_done_q <= shot_done_d;
    end
  end

  always_comb begin
    ball_x    = x_q;
    ball_y    = y_q;
    in_flight = (state_q == StFlight);
    shot_done = shot_done_q;
    made      = made_q;
  end

endmodule
